// File: rtl/src_ram_frame_reader.sv
// src_ram_frame_reader
// Reads one LPC analysis frame out of the source sample RAM through its
// second port and streams it as a valid/ready sample stream to the
// autocorrelation stage. Never writes the RAM.
//
// Optional feature macro: SRC_RAM_WRAP_EN
//   defined   : no range rejection, read pointer wraps 1023 -> 0
//               (circular sample buffer); err only for len > 2**ADDR_W.
//   undefined : frames with base+len > 2**ADDR_W are rejected with err.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle frame request (only honoured in IDLE)
//   cfg_base, cfg_len frame base word address / length, latched on start
//   busy, done, err   frame status (done pulses once, err valid with done)
//   ram_*             RAM port 2 (address, chipselect, write=0, clken=1,
//                     readdata valid one cycle after the address)
//   out_data/valid/ready/last  sample stream to the downstream stage
//
// State table:
//   IDLE  | waiting for start
//   CHECK | length / range check of the latched frame
//   FETCH | issuing reads while buffer credit is available
//   DRAIN | all reads issued, waiting for the last word handshake
//   FIN   | done pulse, back to IDLE
module src_ram_frame_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_FIN} state_t;

  // One extra bit beyond the length so base+len cannot overflow for any cfg_len.
  localparam int SUM_W = LEN_W + 1;
  localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADDR_W;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_rem;
  logic [LEN_W-1:0]    r_sent;
  logic                r_inflight;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_buf0;
  logic [DATA_W-1:0]   r_buf1;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [SUM_W-1:0]    w_end;
  logic                w_range_err;
  logic                w_pop;
  logic [2:0]          w_load;
  logic [2:0]          w_lim;
  logic                w_issue;
  logic                w_last_word;

  // r_rd_ptr still holds the latched base while in CHECK.
  assign w_end = SUM_W'(r_rd_ptr) + SUM_W'(r_len);
`ifdef SRC_RAM_WRAP_EN
  assign w_range_err = SUM_W'(r_len) > DEPTH;
`else
  assign w_range_err = w_end > DEPTH;
`endif

  assign out_valid   = (r_cnt != 2'd0);
  assign w_pop       = out_valid & out_ready;
  assign w_last_word = (r_sent == (r_len - LEN_W'(1)));

  // Credit: buffered + in-flight words, counting a word leaving this cycle
  // as free, must stay below two so a captured word always has a slot.
  // The pop term keeps one word per cycle under continuous out_ready.
  assign w_load  = 3'(r_cnt) + 3'(r_inflight);
  assign w_lim   = 3'd2 + 3'(w_pop);
  assign w_issue = (r_state == S_FETCH) && (w_load < w_lim);

  assign ram_chipselect = w_issue;
  assign ram_address    = r_rd_ptr;
  assign ram_write      = 1'b0;
  assign ram_clken      = 1'b1;

  assign out_data = r_buf0;
  assign out_last = out_valid & w_last_word;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_rem      <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;

      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_rem    <= r_rem - LEN_W'(1);
      end

      if (w_pop) r_sent <= r_sent + LEN_W'(1);

      // Two-entry buffer, r_buf0 is the head; a read in flight lands now.
      case (r_cnt)
        2'd0: begin
          if (r_inflight) begin
            r_buf0 <= ram_readdata;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (r_inflight && w_pop) begin
            r_buf0 <= ram_readdata;
          end else if (r_inflight) begin
            r_buf1 <= ram_readdata;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_buf0 <= r_buf1;
            if (r_inflight) r_buf1 <= ram_readdata;
            else            r_cnt  <= 2'd1;
          end
        end
      endcase

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd_ptr <= cfg_base;
            r_len    <= cfg_len;
            r_rem    <= cfg_len;
            r_sent   <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_len == '0) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (w_range_err) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue && (r_rem == LEN_W'(1))) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && w_last_word) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_src_ram_frame_reader.sv
// Testbench for src_ram_frame_reader: RAM model with one-cycle read latency,
// queue-based scoreboard for read addresses, output words and done/err.
module tb_src_ram_frame_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_len;
  logic          busy, done, err;
  logic [AW-1:0] ram_address;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_readdata;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;

  src_ram_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memval(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = memval(i);
  initial ram_readdata = '0;
  always @(posedge clk) if (ram_chipselect) ram_readdata <= mem[ram_address];

  // scoreboard
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic          done_q[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int t_start = 0;
  int first_v = -1, first_cs = -1, done_c = -1;
  int done_cnt = 0, acc_cnt = 0, cs_cnt = 0, max_out = 0;
  bit bp_en = 0;
  int bp_k = 0;
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit stall_prev = 0;
  logic [DW-1:0] stall_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin out_ready = bp_pat[bp_k % 4]; bp_k++; end
      else out_ready = 1'b1;
    end
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (ram_chipselect) begin
        cs_cnt++;
        if (first_cs < 0) first_cs = cyc;
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_read: addr %0h, expected no read", ram_address);
        end else chk("rd_addr", 64'(ram_address), 64'(addr_q.pop_front()));
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(stall_data));
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: data %0h, expected none", out_data);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e[DW-1:0]));
          chk("out_last", 64'(out_last), 64'(e[DW]));
        end
      end
      if (cs_cnt - acc_cnt > max_out) max_out = cs_cnt - acc_cnt;
      if (done) begin
        done_cnt++;
        done_c = cyc;
        if (done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: err %0b, expected no done", err);
        end else chk("done_err", 64'(err), 64'(done_q.pop_front()));
      end
    end
  end

  task automatic push_frame(input int base, input int len, input bit e);
    if (!e) for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = AW'(base + i);
      addr_q.push_back(a);
      exp_q.push_back({(i == len - 1), memval(int'(a))});
    end
    done_q.push_back(e);
  endtask

  task automatic start_frame(input int base, input int len);
    @(posedge clk); #1;
    cfg_base = AW'(base); cfg_len = LW'(len); start = 1'b1;
    t_start = cyc; first_v = -1; first_cs = -1; done_c = -1;
    cs_cnt = 0; acc_cnt = 0; max_out = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
    chk({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit hit;
    reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    chk("rst_valid_last_cs", 64'({out_valid, out_last, ram_chipselect}), 64'd0);
    chk("rst_addr", 64'(ram_address), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("ram_write_clken", 64'({ram_write, ram_clken}), 64'b01);
    @(posedge clk); #1; reset = 1'b0;

    // basic frame with timing
    push_frame(16, 4, 0);
    start_frame(16, 4);
    wait_done("basic", 50);
    chk("basic_first_read", 64'(first_cs - t_start), 64'd2);
    chk("basic_first_valid", 64'(first_v - t_start), 64'd4);
    chk("basic_done_time", 64'(done_c - t_start), 64'd8);

    // backpressure
    bp_en = 1; bp_k = 0;
    push_frame(0, 8, 0);
    start_frame(0, 8);
    wait_done("bp", 200);
    bp_en = 0;
    chk("bp_word_count", 64'(acc_cnt), 64'd8);
    chk("bp_max_buffered_ok", 64'(max_out <= 2), 64'd1);

    // zero length
    push_frame(5, 0, 0);
    start_frame(5, 0);
    wait_done("len0", 20);
    chk("len0_done_time", 64'(done_c - t_start), 64'd2);
    chk("len0_reads", 64'(cs_cnt), 64'd0);

`ifdef SRC_RAM_WRAP_EN
    push_frame(1022, 4, 0);
    start_frame(1022, 4);
    wait_done("wrap", 50);
    chk("wrap_reads", 64'(cs_cnt), 64'd4);
    push_frame(1023, 2, 0);
    start_frame(1023, 2);
    wait_done("wrap2", 50);
    chk("wrap2_err", 64'(err), 64'd0);
`else
    push_frame(1020, 8, 1);
    start_frame(1020, 8);
    wait_done("range", 20);
    chk("range_done_time", 64'(done_c - t_start), 64'd2);
    chk("range_reads", 64'(cs_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("range_err_held", 64'(err), 64'd1);
    push_frame(1023, 2, 1);
    start_frame(1023, 2);
    wait_done("edge_rej", 20);
    chk("edge_rej_reads", 64'(cs_cnt), 64'd0);
`endif
    // last legal word, also clears err
    push_frame(1023, 1, 0);
    start_frame(1023, 1);
    wait_done("edge_ok", 30);
    chk("edge_ok_err", 64'(err), 64'd0);
    chk("edge_ok_words", 64'(acc_cnt), 64'd1);

    // reset mid-frame
    push_frame(256, 16, 0);
    start_frame(256, 16);
    hit = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (acc_cnt >= 5) begin hit = 1; break; end
    end
    chk("mid_reached_5", 64'(hit), 64'd1);
    reset = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    exp_q.delete(); addr_q.delete(); done_q.delete();
    repeat (5) @(posedge clk);
    #1 chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    push_frame(0, 2, 0);
    start_frame(0, 2);
    wait_done("after_rst", 30);
    chk("after_rst_words", 64'(acc_cnt), 64'd2);

    // start while busy is ignored
    d0 = done_cnt;
    push_frame(64, 6, 0);
    start_frame(64, 6);
    repeat (2) @(posedge clk);
    #1 cfg_base = AW'(128); cfg_len = LW'(3); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start", 60);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_start_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_words", 64'(acc_cnt), 64'd6);
    chk("final_addr_q_empty", 64'(addr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
